cordic_vec_prerotate: RTL and testbench

- Input conditioning stage placed directly upstream of the vectoring CORDIC pipeline. It folds any (X,Y) vector into the right half-plane with a ±90° pre-rotation, so CORDIC convergence covers the full ±180° range.
- Supplies the CORDIC X, Y and seed-angle (THETA_IN) inputs.
- Carries a valid/quadrant side-channel through a delay line so downstream logic knows which CORDIC outputs are real samples.

---
 rtl/cordic_vec_prerotate.sv | 147 ++++++++++++++
 tb/tb_cordic_vec_prerotate.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_vec_prerotate.sv
// rtl/cordic_vec_prerotate.sv - folds (X,Y) into the right half-plane ahead of a vectoring CORDIC
// Optional macro PREROT_HEADROOM_EN: halves x_out/y_out (floor) to absorb the CORDIC gain.
module cordic_vec_prerotate #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 11,
  parameter int CORDIC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] theta_out,
  output logic                    out_valid,
  output logic                    res_valid,
  output logic [1:0]              res_quad,
  output logic                    sat_flag,
  output logic [15:0]             sat_count
);

  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

  // pi/2 * 2^30 = 1686629713.06; rescale to FRAC bits and round half-up
  localparam logic [63:0] PI2_SCALED = (64'd1686629713 << FRAC) + (64'd1 << 29);
  localparam logic [63:0] PI2_WIDE   = PI2_SCALED >> 30;
  localparam logic signed [WIDTH-1:0] PI2_POS = PI2_WIDE[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] PI2_NEG = -PI2_POS;

  function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
    sat_neg = (v == SMIN) ? SMAX : -v;
  endfunction

  // Stage A: capture
  logic                    va_q;
  logic signed [WIDTH-1:0] xa_q, ya_q;
  logic [1:0]              quad_a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      va_q     <= 1'b0;
      xa_q     <= '0;
      ya_q     <= '0;
      quad_a_q <= 2'b00;
    end else begin
      va_q <= in_valid;
      if (in_valid) begin
        xa_q     <= x_in;
        ya_q     <= y_in;
        quad_a_q <= {x_in[WIDTH-1], y_in[WIDTH-1]};
      end
    end
  end

  logic signed [WIDTH-1:0] xr_d, yr_d, th_d, xs_d, ys_d;
  logic                    sat_d;

  always_comb begin
    xr_d  = xa_q;
    yr_d  = ya_q;
    th_d  = '0;
    sat_d = 1'b0;
    case (quad_a_q)
      2'b10: begin
        xr_d  = ya_q;
        yr_d  = sat_neg(xa_q);
        th_d  = PI2_POS;
        sat_d = (xa_q == SMIN);
      end
      2'b11: begin
        xr_d  = sat_neg(ya_q);
        yr_d  = xa_q;
        th_d  = PI2_NEG;
        sat_d = (ya_q == SMIN);
      end
      default: begin
        xr_d  = xa_q;
        yr_d  = ya_q;
      end
    endcase
`ifdef PREROT_HEADROOM_EN
    xs_d = xr_d >>> 1;
    ys_d = yr_d >>> 1;
`else
    xs_d = xr_d;
    ys_d = yr_d;
`endif
  end

  // Stage B: registered outputs; data holds across bubbles
  logic                    vb_q, sat_q;
  logic signed [WIDTH-1:0] xb_q, yb_q, thb_q;
  logic [1:0]              quad_b_q;
  logic [15:0]             cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vb_q     <= 1'b0;
      sat_q    <= 1'b0;
      xb_q     <= '0;
      yb_q     <= '0;
      thb_q    <= '0;
      quad_b_q <= 2'b00;
      cnt_q    <= 16'd0;
    end else begin
      vb_q  <= va_q;
      sat_q <= va_q & sat_d;
      if (va_q) begin
        xb_q     <= xs_d;
        yb_q     <= ys_d;
        thb_q    <= th_d;
        quad_b_q <= quad_a_q;
      end
      if (va_q && sat_d && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Side-channel delay line matching the CORDIC latency (CORDIC_LAT must be >= 1)
  logic [2:0] dl_q [CORDIC_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORDIC_LAT; i++) begin
        dl_q[i] <= 3'b000;
      end
    end else begin
      dl_q[0] <= {vb_q, quad_b_q};
      for (int i = 1; i < CORDIC_LAT; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign x_out     = xb_q;
  assign y_out     = yb_q;
  assign theta_out = thb_q;
  assign out_valid = vb_q;
  assign sat_flag  = sat_q;
  assign sat_count = cnt_q;
  assign res_valid = dl_q[CORDIC_LAT-1][2];
  assign res_quad  = dl_q[CORDIC_LAT-1][1:0];

endmodule

// File: tb/tb_cordic_vec_prerotate.sv
// tb/tb_cordic_vec_prerotate.sv - randomized bench against a sample-level pre-rotation model
module tb_cordic_vec_prerotate;
  localparam int W    = 16;
  localparam int FRAC = 11;
  localparam int LAT  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  x_in = '0, y_in = '0;
  logic [W-1:0]  x_out, y_out, theta_out;
  logic          out_valid, res_valid, sat_flag;
  logic [1:0]    res_quad;
  logic [15:0]   sat_count;

  cordic_vec_prerotate #(.WIDTH(W), .FRAC(FRAC), .CORDIC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .x_out(x_out), .y_out(y_out), .theta_out(theta_out), .out_valid(out_valid),
    .res_valid(res_valid), .res_quad(res_quad), .sat_flag(sat_flag), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  typedef struct {
    bit       v;
    int       x, y, th;
    bit       sat;
    bit [1:0] q;
  } rec_t;

  localparam int SMIN = -(2 ** (W-1));
  localparam int SMAX = (2 ** (W-1)) - 1;
  int pi2;

  function automatic int neg_sat(input int v);
    return (v == SMIN) ? SMAX : -v;
  endfunction

  // Quadrant fold from the sign rules; output of one accepted sample
  function automatic rec_t prerot(input int x, input int y, input int p2);
    rec_t r;
    r.v = 1'b1;
    r.q = {x < 0, y < 0};
    r.sat = 1'b0;
    if (x >= 0) begin
      r.x = x; r.y = y; r.th = 0;
    end else if (y >= 0) begin
      r.x = y; r.y = neg_sat(x); r.th = p2; r.sat = (x == SMIN);
    end else begin
      r.x = neg_sat(y); r.y = x; r.th = -p2; r.sat = (y == SMIN);
    end
`ifdef PREROT_HEADROOM_EN
    r.x = r.x >>> 1;
    r.y = r.y >>> 1;
`endif
    return r;
  endfunction

  rec_t zero_rec, cur, held;
  rec_t hist [LAT+1];
  bit   a_v;
  int   a_x, a_y, cnt;

  task automatic model_edge(input bit r, input bit v, input int x, input int y);
    if (r) begin
      cur = zero_rec; held = zero_rec; a_v = 1'b0; cnt = 0;
      for (int i = 0; i <= LAT; i++) hist[i] = zero_rec;
      return;
    end
    if (a_v) begin
      cur = prerot(a_x, a_y, pi2);
      held = cur;
    end else begin
      cur = held; cur.v = 1'b0; cur.sat = 1'b0;
    end
    if (cur.v && cur.sat && cnt < 65535) cnt++;
    a_v = v; a_x = x; a_y = y;
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = cur;
  endtask

  task automatic step(input bit r, input bit v, input int x, input int y);
    rst = r; in_valid = v; x_in = x[W-1:0]; y_in = y[W-1:0];
    @(posedge clk);
    model_edge(r, v, x, y);
    @(negedge clk);
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(cur.v));
      chk("x_out", 32'(x_out), 32'(cur.x[W-1:0]));
      chk("y_out", 32'(y_out), 32'(cur.y[W-1:0]));
      chk("theta_out", 32'(theta_out), 32'(cur.th[W-1:0]));
      chk("sat_flag", 32'(sat_flag), 32'(cur.v && cur.sat));
      chk("sat_count", 32'(sat_count), 32'(cnt));
      chk("res_valid", 32'(res_valid), 32'(hist[LAT].v));
      chk("res_quad", 32'(res_quad), 32'(hist[LAT].q));
    end
  endtask

  function automatic int pick();
    logic [W-1:0] r16;
    case ($urandom_range(0, 7))
      0: return SMIN;
      1: return 0;
      2: return -1;
      3: return SMAX;
      default: begin
        r16 = W'($urandom);
        return int'($signed(r16));
      end
    endcase
  endfunction

  initial begin
    zero_rec = '{v: 1'b0, x: 0, y: 0, th: 0, sat: 1'b0, q: 2'b00};
    cur = zero_rec; held = zero_rec; a_v = 1'b0; cnt = 0;
    for (int i = 0; i <= LAT; i++) hist[i] = zero_rec;
    pi2 = int'($floor(3.141592653589793 / 2.0 * (2.0 ** FRAC) + 0.5));
    @(negedge clk);

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("pi2_const", 32'(pi2), 32'd3217);

    step(0, 1, 100, 50);
    step(0, 0, 0, 0);
    chk("dir_q0_x", 32'(x_out), 32'h0000_0064 >> 0);
    chk("dir_q0_v", 32'(out_valid), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("dir_q0_res", 32'(res_valid), 32'd1);

    step(0, 1, -100, 50);
    step(0, 0, 0, 0);
`ifdef PREROT_HEADROOM_EN
    chk("dir_q2_x", 32'(x_out), 32'd25);
    chk("dir_q2_y", 32'(y_out), 32'd50);
`else
    chk("dir_q2_x", 32'(x_out), 32'd50);
    chk("dir_q2_y", 32'(y_out), 32'd100);
`endif
    chk("dir_q2_th", 32'(theta_out), 32'd3217);

    step(0, 1, -100, -50);
    step(0, 1, -1, SMIN);
    step(0, 1, 0, 0);
    step(0, 1, -7, 0);
    step(0, 0, 0, 0);
    step(0, 1, 11, -22);
    step(0, 1, -33, 44);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    step(0, 1, 5, 6);
    step(0, 1, -7, 8);
    step(0, 1, -9, -10);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, pick(), pick());
    end

    step(1, 0, 0, 0);
    chk_en = 1'b0;
    for (int i = 0; i < 70000; i++) step(0, 1, -1, SMIN);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, -1, SMIN);
    chk("sat_hold", 32'(sat_count), 32'h0000_FFFF);
    chk("sat_flag_hold", 32'(sat_flag), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
